// File: rtl/cix_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cix_seq : multi-cycle chunked leading/trailing/full bit counter      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

module cix #(
  parameter int ORDER = 3
) (
  input  logic [2**ORDER-1:0] in,
  input  logic                clz,
  input  logic                ctz,
  output logic [ORDER:0]      out,
  output logic                zero
);
  localparam int W = 2**ORDER;
  localparam logic [ORDER:0] c_one = 1;

  logic [ORDER:0] w_cnt;
  logic           w_found;

  // Leading/trailing stop at the first set bit; both-set counts every zero bit.
  always_comb begin
    w_cnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (clz && !ctz) begin
        if (!w_found) begin
          if (in[W-1-i]) w_found = 1'b1;
          else           w_cnt   = w_cnt + c_one;
        end
      end else if (ctz && !clz) begin
        if (!w_found) begin
          if (in[i]) w_found = 1'b1;
          else       w_cnt   = w_cnt + c_one;
        end
      end else if (clz && ctz) begin
        if (!in[i]) w_cnt = w_cnt + c_one;
      end
    end
  end

  assign out  = w_cnt;
  assign zero = ~|in;
endmodule

module cix_seq #(
  parameter int ORDER       = 3,
  parameter int CHUNK_ORDER = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   clz,
  input  logic                                   ctz,
  input  logic                                   inv,
  input  logic [2**(ORDER+CHUNK_ORDER)-1:0]      in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ORDER+CHUNK_ORDER:0]             out,
  output logic                                   zero
);
  localparam int W = 2**ORDER;
  localparam int N = 2**(ORDER+CHUNK_ORDER);
  localparam int A = ORDER + CHUNK_ORDER + 1;
  localparam logic [CHUNK_ORDER-1:0] c_last_chunk = '1;
  localparam logic [CHUNK_ORDER-1:0] c_cnt_one    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic                   r_clz;
  logic                   r_ctz;
  logic [N-1:0]           r_word;
  logic [A-1:0]           r_acc;
  logic [CHUNK_ORDER-1:0] r_cnt;
  logic                   r_zero;

  logic [CHUNK_ORDER-1:0] w_idx;
  logic [W-1:0]           w_chunk;
  logic [ORDER:0]         w_cix_out;
  logic                   w_cix_zero;
  logic                   w_stop;

  // Trailing-only walks up from chunk 0; everything else walks down from the top.
  assign w_idx   = (r_ctz && !r_clz) ? r_cnt : ~r_cnt;
  assign w_chunk = r_word[{w_idx, {ORDER{1'b0}}} +: W];

  cix #(.ORDER(ORDER)) u_cix (
    .in   (w_chunk),
    .clz  (r_clz),
    .ctz  (r_ctz),
    .out  (w_cix_out),
    .zero (w_cix_zero)
  );

  assign w_stop = ((r_clz ^ r_ctz) && !w_cix_zero) || (r_cnt == c_last_chunk);

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (w_stop) w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clz  <= 1'b0;
      r_ctz  <= 1'b0;
      r_word <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_clz  <= clz;
            r_ctz  <= ctz;
            r_word <= in ^ {N{inv}};
            r_acc  <= '0;
            r_cnt  <= '0;
            r_zero <= 1'b1;
          end
        end
        ST_RUN: begin
          r_acc  <= r_acc + {{CHUNK_ORDER{1'b0}}, w_cix_out};
          r_zero <= r_zero & w_cix_zero;
          r_cnt  <= r_cnt + c_cnt_one;
        end
        default: ;
      endcase
    end
  end

  assign out  = r_acc;
  assign zero = r_zero;
endmodule

`default_nettype wire

// File: tb/tb_cix_seq.sv
`default_nettype none
// Testbench for cix_seq: directed table, hand-written corner sequences and
// randomized operations against a whole-word reference model.
module tb_cix_seq;
  localparam int C = 4;
  localparam int W = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_clz = 1'b0, op_ctz = 1'b0, op_inv = 1'b0;
  logic [31:0] word = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  cix_seq #(.ORDER(3), .CHUNK_ORDER(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .clz(op_clz), .ctz(op_ctz), .inv(op_inv), .in(word),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .zero(zero)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        c, t, v;
    logic [31:0] w;
    int          eo, ez, ek;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: whole-word semantics, no notion of chunks except for k.
  function automatic void model(input logic c, t, v, input logic [31:0] w0,
                                output int o, output int z, output int k);
    logic [31:0] w;
    int i;
    w = v ? ~w0 : w0;
    o = 0;
    z = (w == 32'd0) ? 1 : 0;
    k = C;
    if (c && !t) begin
      i = 31;
      while (i >= 0 && !w[i]) begin o++; i--; end
      if (w != 0) k = o / W + 1;
    end else if (t && !c) begin
      i = 0;
      while (i < 32 && !w[i]) begin o++; i++; end
      if (w != 0) k = o / W + 1;
    end else if (c && t) begin
      for (int b = 0; b < 32; b++) if (!w[b]) o++;
    end
  endfunction

  task automatic issue(input logic c, t, v, input logic [31:0] w);
    int n;
    n = 0;
    op_clz = c; op_ctz = t; op_inv = v; word = w;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin @(posedge clock); #1; n++; end
    check("issue_ready", int'(in_ready), 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int k);
    k = 0;
    do begin @(posedge clock); #1; k++; end while (!out_valid && k < 20);
    check("result_arrives", int'(out_valid), 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic c, t, v, input logic [31:0] w,
                        input int eo, input int ez, input int ek);
    int k;
    issue(c, t, v, w);
    wait_result(k);
    check({tag, "_out"},  int'(out),  eo);
    check({tag, "_zero"}, int'(zero), ez);
    check({tag, "_k"},    k,          ek);
    consume();
  endtask

  vec_t vecs[10];

  initial begin
    int k, eo, ez, ek;
    logic c, t, v;
    logic [31:0] w;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0001_0000, 15, 0, 2};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0001_0000, 16, 0, 3};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_00FF,  8, 0, 2};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'hF0F0_0001,  9, 0, 4};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'hF0F0_0001, 23, 0, 4};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32, 1, 4};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32, 1, 4};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h1234_5678,  0, 0, 4};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32, 1, 4};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000,  0, 0, 1};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out",       int'(out),       0);
    check("rst_zero",      int'(zero),      0);
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("stray_out_ready", int'(out_valid), 0);
    out_ready = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].t, vecs[i].v, vecs[i].w,
             vecs[i].eo, vecs[i].ez, vecs[i].ek);

    // Back-pressure with a second request waiting.
    issue(1'b1, 1'b0, 1'b0, 32'h0001_0000);
    wait_result(k);
    op_clz = 1'b0; op_ctz = 1'b1; op_inv = 1'b0; word = 32'h0001_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), int'(out_valid), 1);
      check($sformatf("bp_out%0d", i),   int'(out),       15);
      check($sformatf("bp_zero%0d", i),  int'(zero),      0);
      check($sformatf("bp_ready%0d", i), int'(in_ready),  0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", int'(in_ready),  1);
    check("bp_idle_valid", int'(out_valid), 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("bp_second_accepted", int'(in_ready), 0);
    wait_result(k);
    check("bp2_out",  int'(out),  16);
    check("bp2_zero", int'(zero), 0);
    check("bp2_k",    k,          3);
    consume();

    // Reset in the second RUN cycle of a popcount.
    issue(1'b1, 1'b1, 1'b1, 32'hF0F0_0001);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rr_in_ready", int'(in_ready), 1);
    check("rr_out",      int'(out),      0);
    check("rr_zero",     int'(zero),     0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_no_valid%0d", i), int'(out_valid), 0);
      @(posedge clock); #1;
    end
    run_op("rr_clz", 1'b1, 1'b0, 1'b0, 32'h8000_0000, 0, 0, 1);

    // Randomized ops; chunks biased toward all-zero / all-one bytes.
    for (int i = 0; i < 60; i++) begin
      c = 1'($urandom_range(0, 1));
      t = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      for (int b = 0; b < 4; b++) begin
        case ($urandom_range(0, 3))
          0, 1: w[b*8 +: 8] = 8'h00;
          2:    w[b*8 +: 8] = 8'hFF;
          default: w[b*8 +: 8] = 8'($urandom);
        endcase
      end
      model(c, t, v, w, eo, ez, ek);
      run_op($sformatf("rnd%0d", i), c, t, v, w, eo, ez, ek);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
